// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side signals of the fetch stage
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        instr_ack;
    logic        PCSrc;
    logic [31:0] Result;

    modport master (
        output imem_req, imem_addr, Instr, instr_valid, PC, PCPlus8,
        input  imem_rdata, imem_ready, instr_ack, PCSrc, Result
    );

    modport slave (
        input  imem_req, imem_addr, Instr, instr_valid, PC, PCPlus8,
        output imem_rdata, imem_ready, instr_ack, PCSrc, Result
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, instruction fetch with one-entry prefetch buffer and branch drain
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, EXEC, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q, instr_q, pf_buf_q, drain_addr_q;
    logic        valid_q, pf_valid_q;
    logic [31:0] pc_plus4;
    logic        req, done;

    // request is idle only while a prefetched word is already buffered
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        req      = !reset && !(state_q == EXEC && pf_valid_q);
        done     = req && bus.imem_ready;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = state_q == FETCH ? pc_q : state_q == DRAIN ? drain_addr_q : pc_plus4;
    assign bus.Instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.PC          = pc_q;
    assign bus.PCPlus8     = pc_q + 32'd8;

    // fetch FSM with registered decode-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_buf_q     <= '0;
            drain_addr_q <= '0;
        end else begin
            case (state_q)
                FETCH: if (done) begin
                    instr_q <= bus.imem_rdata;
                    valid_q <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: if (!bus.instr_ack) begin
                    if (done) begin
                        pf_buf_q   <= bus.imem_rdata;
                        pf_valid_q <= 1'b1;
                    end
                end else if (!bus.PCSrc) begin
                    pc_q <= pc_plus4;
                    if (pf_valid_q) begin
                        instr_q    <= pf_buf_q;
                        pf_valid_q <= 1'b0;
                    end else if (done) begin
                        instr_q <= bus.imem_rdata;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end else begin
                    pc_q       <= bus.Result & ~32'd3;
                    pf_valid_q <= 1'b0;
                    valid_q    <= 1'b0;
                    if (req && !done) begin
                        drain_addr_q <= pc_plus4;
                        state_q      <= DRAIN;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                DRAIN: if (done) state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized instruction-stream reference model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0, ack = 1'b0, pcsrc = 1'b0;
    logic [31:0] result = '0;
    int          pass_cnt = 0, total_cnt = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h100)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = mem(bus.imem_addr);
    assign bus.instr_ack  = ack;
    assign bus.PCSrc      = pcsrc;
    assign bus.Result     = result;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ready = 1'b0; ack = 1'b0; pcsrc = 1'b0; result = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ready = 1'b1; ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else pass_cnt++;
            total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid); else pass_cnt++;
        end
        total_cnt++; if (bus.Instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", bus.Instr); else pass_cnt++;
        reset = 1'b0; ready = 1'b0;
        #1;
        total_cnt++; if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) $display("FAIL reset_first_addr: got %h/%b want 100/1", bus.imem_addr, bus.imem_req); else pass_cnt++;
    endtask

    task automatic test_sequential();
        do_reset();
        ready = 1'b1; ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc;
            @(negedge clk);
            pc = 32'h100 + 32'(4 * i);
            total_cnt++; if (bus.instr_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.instr_valid); else pass_cnt++;
            total_cnt++; if (bus.Instr !== mem(pc)) $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.Instr, mem(pc)); else pass_cnt++;
            total_cnt++; if (bus.PC !== pc) $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.PC, pc); else pass_cnt++;
            total_cnt++; if (bus.PCPlus8 !== pc + 32'd8) $display("FAIL seq_pcplus8[%0d]: got %h want %h", i, bus.PCPlus8, pc + 32'd8); else pass_cnt++;
        end
        ack = 1'b0;
    endtask

    task automatic test_branch_buffered();
        do_reset();
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL bb_req_idle: got %b want 0", bus.imem_req); else pass_cnt++;
        ack = 1'b1; pcsrc = 1'b1; result = 32'h203;
        @(negedge clk);
        ack = 1'b0; pcsrc = 1'b0;
        total_cnt++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) $display("FAIL bb_target: got %h/%b want 200/1", bus.imem_addr, bus.imem_req); else pass_cnt++;
        total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL bb_bubble: got %b want 0", bus.instr_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.instr_valid !== 1'b1 || bus.Instr !== mem(32'h200) || bus.PC !== 32'h200) $display("FAIL bb_instr: got %b/%h/%h want 1/%h/200", bus.instr_valid, bus.Instr, bus.PC, mem(32'h200)); else pass_cnt++;
    endtask

    task automatic test_branch_outstanding();
        do_reset();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0; ack = 1'b1; pcsrc = 1'b1; result = 32'h400;
        @(negedge clk);
        ack = 1'b0; pcsrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) $display("FAIL drain_addr[%0d]: got %b/%h want 1/104", i, bus.imem_req, bus.imem_addr); else pass_cnt++;
            total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL drain_valid[%0d]: got %b want 0", i, bus.instr_valid); else pass_cnt++;
            if (i == 2) ready = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (bus.imem_addr !== 32'h400 || bus.instr_valid !== 1'b0) $display("FAIL drain_refetch: got %h/%b want 400/0", bus.imem_addr, bus.instr_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.instr_valid !== 1'b1 || bus.Instr !== mem(32'h400) || bus.PC !== 32'h400) $display("FAIL drain_instr: got %b/%h/%h want 1/%h/400", bus.instr_valid, bus.Instr, bus.PC, mem(32'h400)); else pass_cnt++;
    endtask

    task automatic test_stall();
        int hs = 0;
        do_reset();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0; ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (bus.instr_valid !== 1'b1 || bus.Instr !== mem(32'h100) || bus.PC !== 32'h100) $display("FAIL stall_hold[%0d]: got %b/%h/%h want 1/%h/100", i, bus.instr_valid, bus.Instr, bus.PC, mem(32'h100)); else pass_cnt++;
            if (i < 3) begin
                total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) $display("FAIL stall_pf_addr[%0d]: got %b/%h want 1/104", i, bus.imem_req, bus.imem_addr); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req_idle[%0d]: got %b want 0", i, bus.imem_req); else pass_cnt++;
            end
            ready = (i == 2);
            if (bus.imem_req && ready) hs++;
            @(negedge clk);
        end
        total_cnt++; if (hs != 1) $display("FAIL stall_prefetch_count: got %0d want 1", hs); else pass_cnt++;
        ack = 1'b1; ready = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        total_cnt++; if (bus.Instr !== mem(32'h104) || bus.PC !== 32'h104) $display("FAIL stall_buffered: got %h/%h want %h/104", bus.Instr, bus.PC, mem(32'h104)); else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        ready = 1'b1;
        @(negedge clk);
        ack = 1'b1; pcsrc = 1'b1; result = 32'hFFFF_FFFF;
        @(negedge clk);
        ack = 1'b0; pcsrc = 1'b0;
        total_cnt++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.PC !== 32'hFFFF_FFFC || bus.PCPlus8 !== 32'h4) $display("FAIL wrap_pcplus8: got %h/%h want fffffffc/4", bus.PC, bus.PCPlus8); else pass_cnt++;
        ack = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.PC !== 32'h0 || bus.Instr !== mem(32'h0) || bus.instr_valid !== 1'b1) $display("FAIL wrap_pc: got %h/%h/%b want 0/%h/1", bus.PC, bus.Instr, bus.instr_valid, mem(32'h0)); else pass_cnt++;
        ready = 1'b0; pcsrc = 1'b1; result = 32'h400;
        @(negedge clk);
        ack = 1'b0; pcsrc = 1'b0;
        total_cnt++; if (bus.imem_addr !== 32'h4 || bus.instr_valid !== 1'b0) $display("FAIL wrap_drain: got %h/%b want 4/0", bus.imem_addr, bus.instr_valid); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus.imem_req !== 1'b0 || bus.PC !== 32'h100 || bus.instr_valid !== 1'b0) $display("FAIL async_reset: got %b/%h/%b want 0/100/0", bus.imem_req, bus.PC, bus.instr_valid); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0; ready = 1'b1;
        #1;
        total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL reset_refetch: got %b/%h want 1/100", bus.imem_req, bus.imem_addr); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.instr_valid !== 1'b1 || bus.Instr !== mem(32'h100)) $display("FAIL reset_instr_after: got %b/%h want 1/%h", bus.instr_valid, bus.Instr, mem(32'h100)); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] model_pc = 32'h100, prev_addr = '0;
        logic        prev_pending = 1'b0;
        int          retired = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_pending) begin
                total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) $display("FAIL rnd_hold[%0d]: got %b/%h want 1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr); else pass_cnt++;
            end
            if (bus.instr_valid) begin
                total_cnt++; if (bus.PC !== model_pc || bus.Instr !== mem(model_pc) || bus.PCPlus8 !== model_pc + 32'd8) $display("FAIL rnd_stream[%0d]: got %h/%h/%h want %h/%h/%h", cyc, bus.PC, bus.Instr, bus.PCPlus8, model_pc, mem(model_pc), model_pc + 32'd8); else pass_cnt++;
            end
            ack = ($urandom_range(0, 3) != 0);
            pcsrc = ($urandom_range(0, 4) == 0);
            result = $urandom;
            ready = ($urandom_range(0, 9) < 6);
            if (bus.instr_valid && ack) begin
                model_pc = pcsrc ? (result & ~32'd3) : model_pc + 32'd4;
                retired++;
            end
            prev_pending = bus.imem_req && !ready;
            prev_addr = bus.imem_addr;
            @(negedge clk);
        end
        ack = 1'b0; pcsrc = 1'b0;
        total_cnt++; if (retired < 300) $display("FAIL rnd_progress: got %0d retired want >=300", retired); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_buffered();
        test_branch_outstanding();
        test_stall();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
